// File: rtl/pipe_pkg.sv
// Shared pipeline-control types: hazard FSM state encoding, zero register and the NOP
// instruction that an IF/ID flush loads.
package pipe_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping; clr wins over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: memory wait > branch redirect > load-use > normal.
// Decisions are combinational from state and inputs; state, timeout and counters are registered.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int MEM_TMO = 64
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rd,
  input  logic             ex_mem_br_taken,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_en,
  output logic             en_if_id,
  output logic             en_id_ex,
  output logic             en_ex_mem,
  output logic             en_mem_wb,
  output logic             flush_if_id,
  output logic             bubble_id_ex,
  output logic             flush_ex_mem,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] ldu_cnt
);

  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(MEM_TMO);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] tmo, tmo_nxt;
  logic             ldu;
  logic             set_err;
  logic             inc_flush;
  logic             inc_ldu;

  assign ldu = id_ex_memread && (id_ex_rd != REG_ZERO) &&
               ((id_ex_rd == id_rs1) || (id_ex_rd == id_rs2));

  always_comb begin
    state_nxt    = RUN;
    tmo_nxt      = '0;
    set_err      = 1'b0;
    inc_flush    = 1'b0;
    inc_ldu      = 1'b0;
    pc_en        = 1'b1;
    en_if_id     = 1'b1;
    en_id_ex     = 1'b1;
    en_ex_mem    = 1'b1;
    en_mem_wb    = 1'b1;
    flush_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    flush_ex_mem = 1'b0;

    if ((state == MEM_WAIT) && !dmem_ack && (tmo == TMO_LIM)) begin
      // Timed out: drop the access and let the pipeline move on.
      set_err = 1'b1;
    end else if ((state == MEM_WAIT) ? !dmem_ack : (dmem_req && !dmem_ack)) begin
      pc_en     = 1'b0;
      en_if_id  = 1'b0;
      en_id_ex  = 1'b0;
      en_ex_mem = 1'b0;
      en_mem_wb = 1'b0;
      state_nxt = MEM_WAIT;
      tmo_nxt   = (state == RUN) ? CNT_W'(1) : tmo + 1'b1;
    end else if (ex_mem_br_taken) begin
      flush_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
      flush_ex_mem = 1'b1;
      inc_flush    = 1'b1;
    end else if (ldu) begin
      pc_en        = 1'b0;
      en_if_id     = 1'b0;
      bubble_id_ex = 1'b1;
      inc_ldu      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state   <= RUN;
      tmo     <= '0;
      mem_err <= 1'b0;
    end else begin
      state <= state_nxt;
      tmo   <= tmo_nxt;
      if (set_err) begin
        mem_err <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .inc    (!pc_en),
    .clr    (1'b0),
    .q      (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .inc    (inc_flush),
    .clr    (1'b0),
    .q      (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_ldu_cnt (
    .clk    (clk),
    .arst_n (arst_n),
    .inc    (inc_ldu),
    .clr    (1'b0),
    .q      (ldu_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scenarios plus random traffic checked every cycle against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int MEM_TMO = 4;
  localparam int SAT     = (1 << CNT_W) - 1;

  logic             clk;
  logic             arst_n;
  logic [4:0]       id_rs1, id_rs2, id_ex_rd;
  logic             id_ex_memread, ex_mem_br_taken, dmem_req, dmem_ack;
  logic             pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic             flush_if_id, bubble_id_ex, flush_ex_mem, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, ldu_cnt;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TMO(MEM_TMO)) dut (
    .clk             (clk),
    .arst_n          (arst_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_ex_memread   (id_ex_memread),
    .id_ex_rd        (id_ex_rd),
    .ex_mem_br_taken (ex_mem_br_taken),
    .dmem_req        (dmem_req),
    .dmem_ack        (dmem_ack),
    .pc_en           (pc_en),
    .en_if_id        (en_if_id),
    .en_id_ex        (en_id_ex),
    .en_ex_mem       (en_ex_mem),
    .en_mem_wb       (en_mem_wb),
    .flush_if_id     (flush_if_id),
    .bubble_id_ex    (bubble_id_ex),
    .flush_ex_mem    (flush_ex_mem),
    .mem_err         (mem_err),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .ldu_cnt         (ldu_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: are we waiting on memory, for how many cycles so far, plus counts.
  bit m_waiting;
  int m_waited;
  bit m_err;
  int m_stall, m_flush, m_ldu;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int x);
    return (x < SAT) ? x + 1 : SAT;
  endfunction

  task automatic model_reset();
    m_waiting = 0;
    m_waited  = 0;
    m_err     = 0;
    m_stall   = 0;
    m_flush   = 0;
    m_ldu     = 0;
  endtask

  // Called at posedge+1; asserts reset asynchronously and checks the cleared state at once.
  task automatic do_reset();
    arst_n = 1'b0;
    #2;
    chk("rst_mem_err", mem_err, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_ldu_cnt", ldu_cnt, 0);
    model_reset();
    @(posedge clk);
    #1;
    arst_n = 1'b1;
  endtask

  // One cycle: drive at posedge+1, check on negedge, advance model, return at next posedge+1.
  task automatic step(input bit req, input bit ack, input bit br, input bit mr,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    bit         hz, stall_all, abort;
    logic [7:0] e;
    logic [7:0] got;
    dmem_req        = req;
    dmem_ack        = ack;
    ex_mem_br_taken = br;
    id_ex_memread   = mr;
    id_ex_rd        = rd;
    id_rs1          = rs1;
    id_rs2          = rs2;
    @(negedge clk);
    hz        = mr && (rd != 0) && ((rd == rs1) || (rd == rs2));
    abort     = m_waiting && !ack && (m_waited == MEM_TMO);
    stall_all = !abort && (m_waiting ? !ack : (req && !ack));
    if (abort)          e = 8'b11111_000;
    else if (stall_all) e = 8'b00000_000;
    else if (br)        e = 8'b11111_111;
    else if (hz)        e = 8'b00111_010;
    else                e = 8'b11111_000;
    got = {pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
           flush_if_id, bubble_id_ex, flush_ex_mem};
    chk("ctrl", got, e);
    chk("mem_err", mem_err, m_err);
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
    chk("ldu_cnt", ldu_cnt, m_ldu);
    if (!e[7]) m_stall = sat_inc(m_stall);
    if (!abort && !stall_all && br) m_flush = sat_inc(m_flush);
    if (!abort && !stall_all && !br && hz) m_ldu = sat_inc(m_ldu);
    if (abort) m_err = 1;
    if (stall_all) begin
      m_waited  = m_waiting ? m_waited + 1 : 1;
      m_waiting = 1;
    end else begin
      m_waiting = 0;
      m_waited  = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    arst_n = 1'b0;
    {dmem_req, dmem_ack, ex_mem_br_taken, id_ex_memread} = '0;
    {id_ex_rd, id_rs1, id_rs2} = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;

    // Reset in the middle of a memory wait, then a clean cycle.
    idle();
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    do_reset();
    idle();

    // Load-use on rs2, then rd=0 which must not stall.
    step(0, 0, 0, 1, 5'd5, 5'd1, 5'd5);
    idle();
    chk("ldu_one", ldu_cnt, 1);
    step(0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    idle();

    // Branch redirect coinciding with a load-use.
    do_reset();
    step(0, 0, 1, 1, 5'd5, 5'd5, 5'd2);
    idle();
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_ldu_cnt", ldu_cnt, 0);

    // Memory access acked on the fourth cycle.
    do_reset();
    repeat (3) step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    step(1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    idle();
    chk("wait_stall_cnt", stall_cnt, 3);

    // Timeout: error sticks until reset.
    do_reset();
    repeat (5) step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    chk("tmo_err", mem_err, 1);
    repeat (3) idle();
    chk("tmo_err_sticky", mem_err, 1);
    do_reset();

    // Saturation of the load-use counter.
    repeat (20) begin
      step(0, 0, 0, 1, 5'd7, 5'd7, 5'd3);
      idle();
    end
    chk("ldu_sat", ldu_cnt, SAT);

    // Random traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
